// File: rtl/lsu_wb_io_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lsu_wb_io_responder                                             |
// | Brief    : Wishbone classic IO responder with wait states over scratch RAM |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module lsu_wb_io_responder #(
  parameter int unsigned                    PHYSICAL_ADDR_LEN = 56,
  parameter int unsigned                    WB_DATA_LEN       = 32,
  parameter logic [PHYSICAL_ADDR_LEN-1:0]   BASE_ADDR         = 56'h0000_1000_0000,
  parameter int unsigned                    DEPTH             = 256,
  parameter int unsigned                    WAIT_CYCLES       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_io_cyc_i,
  input  logic                         wb_io_stb_i,
  input  logic                         wb_io_we_i,
  input  logic [PHYSICAL_ADDR_LEN-1:0] wb_io_adr_i,
  input  logic [WB_DATA_LEN-1:0]       wb_io_dat_i,
  input  logic [WB_DATA_LEN/8-1:0]     wb_io_sel_i,
  output logic                         wb_io_ack_o,
  output logic [WB_DATA_LEN-1:0]       wb_io_dat_o,
  output logic [7:0]                   wb_io_err_cnt_o,
  output logic                         wb_io_busy_o
);

  localparam int unsigned c_IDX_W = $clog2(DEPTH);
  localparam int unsigned c_SEL_W = WB_DATA_LEN / 8;
  localparam logic [PHYSICAL_ADDR_LEN:0] c_SPAN     = (PHYSICAL_ADDR_LEN+1)'(4 * DEPTH);
  localparam logic [PHYSICAL_ADDR_LEN:0] c_LO_ADDR  = {1'b0, BASE_ADDR};
  localparam logic [PHYSICAL_ADDR_LEN:0] c_END_ADDR = c_LO_ADDR + c_SPAN;
  localparam logic [3:0]                 c_WAIT     = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [3:0]               r_cnt;
  logic                     r_we;
  logic                     r_inwin;
  logic [c_IDX_W-1:0]       r_idx;
  logic [WB_DATA_LEN-1:0]   r_dat;
  logic [c_SEL_W-1:0]       r_sel;
  logic                     r_ack;
  logic [WB_DATA_LEN-1:0]   r_dat_o;
  logic [7:0]               r_err;
  logic                     r_busy;
  logic [WB_DATA_LEN-1:0]   r_mem [DEPTH];

  logic                     w_in_win;
  logic [c_IDX_W-1:0]       w_idx;
  logic                     w_capture;
  logic                     w_commit;
  logic                     w_c_we;
  logic                     w_c_inwin;
  logic [c_IDX_W-1:0]       w_c_idx;
  logic [WB_DATA_LEN-1:0]   w_c_dat;
  logic [c_SEL_W-1:0]       w_c_sel;

  // Base is word aligned, so the word index only needs the low address bits.
  assign w_in_win = ({1'b0, wb_io_adr_i} >= c_LO_ADDR) && ({1'b0, wb_io_adr_i} < c_END_ADDR);
  assign w_idx    = wb_io_adr_i[c_IDX_W+1:2] - BASE_ADDR[c_IDX_W+1:2];

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_commit  = 1'b0;
    w_c_we    = r_we;
    w_c_inwin = r_inwin;
    w_c_idx   = r_idx;
    w_c_dat   = r_dat;
    w_c_sel   = r_sel;
    case (r_state)
      S_IDLE: begin
        if (wb_io_cyc_i && wb_io_stb_i) begin
          w_capture = 1'b1;
          if (c_WAIT == 4'd0) begin
            // Zero wait states commit straight from the live bus inputs.
            w_next    = S_ACK;
            w_commit  = 1'b1;
            w_c_we    = wb_io_we_i;
            w_c_inwin = w_in_win;
            w_c_idx   = w_idx;
            w_c_dat   = wb_io_dat_i;
            w_c_sel   = wb_io_sel_i;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!wb_io_cyc_i) begin
          w_next = S_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_next   = S_ACK;
          w_commit = 1'b1;
        end
      end
      S_ACK: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ack   <= 1'b0;
      r_dat_o <= '0;
      r_err   <= 8'd0;
      r_busy  <= 1'b0;
      r_we    <= 1'b0;
      r_inwin <= 1'b0;
      r_idx   <= '0;
      r_dat   <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_next;
      r_ack   <= (w_next == S_ACK);
      r_busy  <= (w_next != S_IDLE);
      if (w_capture) begin
        r_cnt   <= c_WAIT;
        r_we    <= wb_io_we_i;
        r_inwin <= w_in_win;
        r_idx   <= w_idx;
        r_dat   <= wb_io_dat_i;
        r_sel   <= wb_io_sel_i;
      end else if (r_state == S_WAIT && wb_io_cyc_i) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        if (!w_c_inwin) begin
          r_dat_o <= '0;
          if (r_err != 8'hFF) begin
            r_err <= r_err + 8'd1;
          end
        end else if (!w_c_we) begin
          r_dat_o <= r_mem[w_c_idx];
        end
      end
    end
  end

  // Scratch array carries no reset; reset only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && w_c_we && w_c_inwin) begin
      for (int k = 0; k < int'(c_SEL_W); k++) begin
        if (w_c_sel[k]) begin
          r_mem[w_c_idx][8*k +: 8] <= w_c_dat[8*k +: 8];
        end
      end
    end
  end

  assign wb_io_ack_o     = r_ack;
  assign wb_io_dat_o     = r_dat_o;
  assign wb_io_err_cnt_o = r_err;
  assign wb_io_busy_o    = r_busy;

endmodule
`default_nettype wire
